// File: rtl/serial_subtractor_16_bit.sv
// Digit-serial 16-bit subtractor: Diff = A - B - Bin, one DIGIT_W slice per cycle.
// Optional signed-overflow output V is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor_16_bit #(
  parameter int DIGIT_W = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic        Busy,
  output logic        Done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic        V
`endif
);

  // state | meaning
  // IDLE  | waiting for Start
  // RUN   | one slice per cycle, counter = slice index
  // DONE  | result valid, one-cycle strobe; Start here re-issues
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NUM_DIGITS = 16 / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [15:0]        a_sh;
  logic [15:0]        b_sh;
  logic [15:0]        acc;

  logic [DIGIT_W-1:0] a_s;
  logic [DIGIT_W-1:0] b_s;
  logic [DIGIT_W:0]   slice;
  logic [15:0]        acc_next;

  // Operands shift right so the active slice is always the low digit;
  // results enter the accumulator from the top and end up in place.
  always_comb begin
    a_s      = a_sh[DIGIT_W-1:0];
    b_s      = b_sh[DIGIT_W-1:0];
    slice    = {1'b0, a_s} - {1'b0, b_s} - (DIGIT_W + 1)'(borrow);
    acc_next = (acc >> DIGIT_W) | (16'(slice[DIGIT_W-1:0]) << (16 - DIGIT_W));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      V      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bin;
            cnt    <= '0;
            acc    <= '0;
            Busy   <= 1'b1;
            state  <= RUN;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          borrow <= slice[DIGIT_W];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            Diff  <= acc_next;
            Bout  <= slice[DIGIT_W];
`ifdef SUB_OVERFLOW_EN
            // Equivalent to borrow-in XOR borrow-out of bit 15.
            V     <= (a_s[DIGIT_W-1] ^ b_s[DIGIT_W-1]) &
                     (slice[DIGIT_W-1] ^ a_s[DIGIT_W-1]);
`endif
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_16_bit.sv
// Scoreboard bench for serial_subtractor_16_bit; expected results are queued at issue
// and compared on each Done strobe. V is checked only when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_16_bit;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 16 / DIGIT_W;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        v;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Bin = 1'b0;
  logic [15:0] Diff;
  logic        Bout;
  logic        Busy;
  logic        Done;
`ifdef SUB_OVERFLOW_EN
  logic        V;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [15:0] prev_diff = '0;

  serial_subtractor_16_bit #(.DIGIT_W(DIGIT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Bout  (Bout),
    .Busy  (Busy),
    .Done  (Done)
`ifdef SUB_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference from integer arithmetic, overflow from signed range.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int   ua, ub, ur, sa, sb_i, sr;
    ua     = int'(a);
    ub     = int'(b);
    ur     = ua - ub - int'(bin);
    e.diff = 16'(ur & 32'hFFFF);
    e.bout = (ur < 0);
    sa     = int'($signed(a));
    sb_i   = int'($signed(b));
    sr     = sa - sb_i - int'(bin);
    e.v    = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  always @(negedge Clk) begin
    if (!Reset && (Busy || Done))
      check_val("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("diff", {16'd0, Diff}, {16'd0, e.diff});
        check_val("bout", {31'd0, Bout}, {31'd0, e.bout});
`ifdef SUB_OVERFLOW_EN
        check_val("v", {31'd0, V}, {31'd0, e.v});
`endif
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input bit poke_run);
    exp_t e;
    int   busy_n;
    bit   seen;
    busy_n = 0;
    seen   = 0;
    e      = model(a, b, bin);
    A = a; B = b; Bin = bin; Start = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (i == 0) Start = 1'b0;
      if (Busy) begin
        busy_n++;
        check_val("hold_diff", {16'd0, Diff}, {16'd0, prev_diff});
        if (poke_run && busy_n == 2) begin
          Start = 1'b1;
          A = ~a;
          B = a;
        end
        if (poke_run && busy_n == 3) Start = 1'b0;
      end
      if (Done) seen = 1;
    end
    if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    check_val("busy_len", busy_n, NUM_DIGITS);
    prev_diff = e.diff;
    @(negedge Clk);
    check_val("post_idle", {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2;
    int   t1, t2;
    bit   seen;

    repeat (3) @(negedge Clk);
    check_val("reset_state", {13'd0, Diff, Bout, Busy, Done}, 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_val("idle", {13'd0, Diff, Bout, Busy, Done}, 32'd0);
    end

    do_op(16'h1234, 16'h0234, 1'b0, 0);
    do_op(16'h1000, 16'h0001, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0);
    do_op(16'h1000, 16'h0FFF, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 0);
    do_op(16'hABCD, 16'h1234, 1'b0, 1);
    for (int i = 0; i < 8; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 0);

    // Back-to-back: Start held through DONE issues the second op.
    e1 = model(16'h0005, 16'h0003, 1'b0);
    e2 = model(16'h0003, 16'h0005, 1'b0);
    A = 16'h0005; B = 16'h0003; Bin = 1'b0; Start = 1'b1;
    sb.push_back(e1);
    seen = 0;
    t1 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1;
        t1 = cyc;
        A = 16'h0003; B = 16'h0005;
        sb.push_back(e2);
      end
    end
    if (!seen) check_val("b2b_timeout1", 32'd0, 32'd1);
    @(negedge Clk);
    Start = 1'b0;
    check_val("b2b_issue", {31'd0, Busy}, 32'd1);
    seen = 0;
    t2 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1;
        t2 = cyc;
      end
    end
    if (!seen) check_val("b2b_timeout2", 32'd0, 32'd1);
    check_val("b2b_spacing", t2 - t1, NUM_DIGITS + 1);
    prev_diff = e2.diff;
    @(negedge Clk);

    // Reset on the second RUN cycle aborts the op; no Done may follow.
    A = 16'h4321; B = 16'h0001; Bin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_val("rst_mid", {13'd0, Diff, Bout, Busy, Done}, 32'd0);
    Reset = 1'b0;
    prev_diff = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_val("rst_quiet", {30'd0, Busy, Done}, 32'd0);
    end

    check_val("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_16_bit.md
# serial_subtractor_16_bit

Digit-serial 16-bit subtractor computing Diff = A − B − Bin over several clock cycles, one DIGIT_W-bit slice per cycle, with the borrow held in a register between slices. It is the subtraction counterpart to the team's 16-bit ripple-carry adder. It serves datapaths that trade latency for a narrow subtract slice. Operands are captured on a Start pulse, and the result is presented with a one-cycle Done strobe.

## Interface
- DIGIT_W, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16; NUM_DIGITS = 16/DIGIT_W
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE or DONE
- A  input  16  minuend, captured when Start accepted
- B  input  16  subtrahend, captured when Start accepted
- Bin  input  1  borrow-in, captured when Start accepted
- Diff  output  16  registered result A − B − Bin mod 2^16
- Bout  output  1  registered borrow-out; 1 iff A < B + Bin (unsigned)
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle strobe; high while in DONE
- V  output  1  signed overflow (present only with SUB_OVERFLOW_EN)

## Operation
- States: IDLE, RUN, DONE; reset state IDLE.
- IDLE:
  - On Start=1, latch A, B, Bin into operand registers.
  - Clear the digit counter. Load the borrow register with Bin.
  - Go to RUN.
  - On Start=0, remain in IDLE.
- RUN, one digit per cycle, digit index k = counter:
  - Compute {b, d} = A[k] − B[k] − borrow on a DIGIT_W-bit slice.
  - Write d into the internal accumulator at slice k. Store b in the borrow register.
  - Increment the counter.
  - When k = NUM_DIGITS−1, load Diff from the accumulator including the final slice. Load Bout with the final b. Go to DONE.
  - Start is ignored in RUN. Operand registers are not re-captured.
- DONE, held for exactly one cycle:
  - If Start=1, capture new operands and go to RUN (back-to-back issue).
  - Otherwise go to IDLE.
- Diff, Bout and V hold their values from the last completed operation until the next completion. They do not change during RUN.
- Arithmetic:
  - Unsigned two's-complement subtraction, result modulo 2^16. No saturation.
  - Borrow ripples between digits only through the borrow register.
- Reset at any cycle:
  - Returns to IDLE and aborts any in-flight operation.
  - Clears Diff=0x0000, Bout=0, V=0, Busy=0, Done=0, the counter, the borrow register, the operand registers and the accumulator.

## Timing
- Start sampled high in IDLE at edge 0, then slices are processed on edges 1..NUM_DIGITS.
- Diff/Bout become valid and Done=1 in the cycle after edge NUM_DIGITS.
  - Default DIGIT_W=4: Done is high in the cycle following edge 4.
- Busy is high for exactly NUM_DIGITS cycles, following edges 0..NUM_DIGITS−1.
- Busy and Done are never high together.
- Back-to-back throughput is one operation per NUM_DIGITS+1 cycles, with Start held during DONE.
- DIGIT_W=16 degenerates to a 2-cycle operation: 1 RUN cycle, then DONE.
- Start is a level sampled per edge; a Start held high through RUN does not cause a second capture until DONE.

## Configuration
- SUB_OVERFLOW_EN defined:
  - Port V exists.
  - V is registered with Diff at the final slice: V = borrow into bit 15 XOR borrow out of bit 15, which is signed overflow of A − B − Bin.
  - V is reset to 0 and holds like Diff.
- SUB_OVERFLOW_EN undefined:
  - Port V and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then idle: all outputs 0 and Busy=0 for 10 cycles with Start=0. Diff=0x0000, Bout=0, Done=0.
- A=0x1234, B=0x0234, Bin=0, Start pulse: Busy high 4 cycles, then Done for 1 cycle with Diff=0x1000, Bout=0.
- Cross-digit borrow ripple:
  - A=0x1000, B=0x0001: Diff=0x0FFF, Bout=0.
  - A=0x0000, B=0x0001: Diff=0xFFFF, Bout=1.
- Bin and overflow (SUB_OVERFLOW_EN):
  - A=0x1000, B=0x0FFF, Bin=1: Diff=0x0000, Bout=0, V=0.
  - A=0x8000, B=0x0001, Bin=0: Diff=0x7FFF, Bout=0, V=1.
- Back-to-back with mid-op Start:
  - Start during RUN is ignored.
  - Start held in DONE issues the next op: 0x0005−0x0003 gives Diff=0x0002, followed by 0x0003−0x0005 giving Diff=0xFFFE, Bout=1.
  - Done pulses are spaced by 5 cycles.
- Reset mid-op: Reset asserted on the 2nd RUN cycle returns to IDLE next edge with Busy=0, Done=0, Diff=0x0000. No Done appears afterward without a new Start.
